// File: rtl/s2p_lane_arbiter_if.sv
// Handshake bundle between the shared deserializer and its lanes/sink.
// master: arbiter side (drives grant/word/status); slave: lanes + sink.
interface s2p_lane_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    localparam int LANE_W = $clog2(LANES);

    logic [LANES-1:0]  req;
    logic [LANES-1:0]  serialDataIn;
    logic [LANES-1:0]  grant;
    logic [WIDTH-1:0]  parallelDataOut;
    logic [LANE_W-1:0] laneId;
    logic              dataValid;
    logic              dataReady;
    logic              busy;
    logic              parityErr;

    modport master (
        input  req, serialDataIn, dataReady,
        output grant, parallelDataOut, laneId,
        output dataValid, busy, parityErr
    );

    modport slave (
        output req, serialDataIn, dataReady,
        input  grant, parallelDataOut, laneId,
        input  dataValid, busy, parityErr
    );
endinterface

// File: rtl/s2p_lane_arbiter.sv
// Round-robin shared serial-to-parallel deserializer for LANES requesters.
// Ports: clk, reset (sync, active-low), bus (s2p_lane_arbiter_if.master).
// Option: S2P_ARB_PARITY_EN adds a trailing even-parity bit per word.
module s2p_lane_arbiter #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                reset,
    s2p_lane_arbiter_if.master  bus
);
    localparam int LANE_W = $clog2(LANES);
`ifdef S2P_ARB_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    // Holds every sampled bit except the one arriving on the final edge.
    localparam int SW    = NB - 1;
    localparam int CNT_W = $clog2(NB);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state_q;
    logic [LANES-1:0]  grant_q;
    logic [SW-1:0]     shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LANE_W-1:0] sel_q;
    logic [LANE_W-1:0] last_q;
    logic [WIDTH-1:0]  word_q;
    logic [LANE_W-1:0] lane_q;
    logic              valid_q;
`ifdef S2P_ARB_PARITY_EN
    logic              perr_q;
`endif

    logic [LANE_W-1:0] sel_d;
    logic [LANE_W-1:0] cand;
    logic              found;
    logic              bit_in;

    assign bit_in = bus.serialDataIn[sel_q];

    // Scan lastLane+1 upward with wrap; first requester wins.
    always_comb begin
        sel_d = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= LANES; i++) begin
            cand = LANE_W'((int'(last_q) + i) % LANES);
            if (!found && bus.req[cand]) begin
                sel_d = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= LANE_W'(LANES - 1);
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
`ifdef S2P_ARB_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        sel_q   <= sel_d;
                        grant_q <= LANES'(1) << sel_d;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.req[sel_q]) begin
                        // Abort: drop partial word, lane loses priority.
                        grant_q <= '0;
                        last_q  <= sel_q;
                        state_q <= IDLE;
                    end else begin
                        shift_q <= SW'({shift_q, bit_in});
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            grant_q <= '0;
                            lane_q  <= sel_q;
                            last_q  <= sel_q;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
`ifdef S2P_ARB_PARITY_EN
                            word_q  <= shift_q;
                            perr_q  <= (^shift_q) ^ bit_in;
`else
                            word_q  <= {shift_q, bit_in};
`endif
                        end
                    end
                end
                HOLD: begin
                    if (bus.dataReady) begin
                        valid_q <= 1'b0;
`ifdef S2P_ARB_PARITY_EN
                        perr_q  <= 1'b0;
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant           = grant_q;
    assign bus.parallelDataOut = word_q;
    assign bus.laneId          = lane_q;
    assign bus.dataValid       = valid_q;
    assign bus.busy            = (state_q != IDLE);
`ifdef S2P_ARB_PARITY_EN
    assign bus.parityErr       = perr_q;
`else
    assign bus.parityErr       = 1'b0;
`endif
endmodule

// File: tb/tb_s2p_lane_arbiter.sv
// Directed self-checking bench for s2p_lane_arbiter (WIDTH=8, LANES=4).
// Lanes serialize lane_data MSB first (plus lane_par when parity is on).
module tb_s2p_lane_arbiter;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
`ifdef S2P_ARB_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    s2p_lane_arbiter_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    s2p_lane_arbiter #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ptr [LANES];
    logic [7:0] lane_data [LANES];
    logic       lane_par [LANES];

    task automatic drive_serial();
        for (int i = 0; i < LANES; i++) begin
            if (ptr[i] < 8) bus.serialDataIn[i] = lane_data[i][7 - ptr[i]];
            else            bus.serialDataIn[i] = lane_par[i];
        end
    endtask

    // One clock: a lane advances its bit pointer for every edge its grant was high.
    task automatic tick();
        logic [LANES-1:0] g;
        g = bus.grant;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < LANES; i++) begin
            if (!bus.grant[i]) ptr[i] = 0;
            else if (g[i])     ptr[i] = ptr[i] + 1;
        end
        drive_serial();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req = 4'hF;
        tick();
        tick();
        tests++;
        if (bus.grant !== 4'h0) begin
            fails++; $display("FAIL reset_grant got %h want 0", bus.grant);
        end
        tests++;
        if (bus.dataValid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid_busy got %b%b want 00", bus.dataValid, bus.busy);
        end
        tests++;
        if (bus.parallelDataOut !== 8'h00 || bus.laneId !== 2'd0) begin
            fails++;
            $display("FAIL reset_data got %h/%0d want 00/0", bus.parallelDataOut, bus.laneId);
        end
        tests++;
        if (bus.parityErr !== 1'b0) begin
            fails++; $display("FAIL reset_perr got %b want 0", bus.parityErr);
        end
        reset = 1'b1;
        bus.req = 4'h0;
        tick();
        tick();
        tests++;
        if (bus.grant !== 4'h0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL release_idle got grant %h busy %b want 0 0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_single();
        int n;
        lane_data[0] = 8'hA5;
        lane_par[0]  = 1'b0;
        bus.req = 4'b0001;
        bus.dataReady = 1'b0;
        tick();
        tests++;
        if (bus.grant !== 4'b0001) begin
            fails++; $display("FAIL single_grant got %b want 0001", bus.grant);
        end
        n = 0;
        while (bus.grant == 4'b0001 && n < 40) begin
            n++;
            tick();
        end
        tests++;
        if (n != NB) begin
            fails++; $display("FAIL single_grant_len got %0d want %0d", n, NB);
        end
        tests++;
        if (bus.dataValid !== 1'b1 || bus.parallelDataOut !== 8'hA5 ||
            bus.laneId !== 2'd0 || bus.parityErr !== 1'b0) begin
            fails++;
            $display("FAIL single_word got v%b %h lane %0d perr %b want v1 a5 lane 0 perr 0",
                     bus.dataValid, bus.parallelDataOut, bus.laneId, bus.parityErr);
        end
        bus.dataReady = 1'b1;
        tick();
        tests++;
        if (bus.dataValid !== 1'b0 || bus.grant !== 4'h0) begin
            fails++;
            $display("FAIL single_accept got v%b grant %b want v0 0000",
                     bus.dataValid, bus.grant);
        end
        tick();
        tests++;
        if (bus.grant !== 4'b0001) begin
            fails++; $display("FAIL single_regrant got %b want 0001", bus.grant);
        end
        bus.req = 4'h0;
        bus.dataReady = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        int t_prev;
        logic [3:0] eg;
        logic [7:0] ed;
        pulse_reset();
        for (int i = 0; i < LANES; i++) begin
            lane_data[i] = 8'(8'h10 + i);
            lane_par[i]  = ^lane_data[i];
        end
        t_prev = 0;
        bus.dataReady = 1'b1;
        bus.req = 4'hF;
        for (int w = 0; w < 5; w++) begin
            n = 0;
            while (bus.grant == 4'h0 && n < 40) begin
                n++;
                tick();
            end
            eg = 4'b0001 << (w % 4);
            tests++;
            if (bus.grant !== eg) begin
                fails++; $display("FAIL rr_grant%0d got %b want %b", w, bus.grant, eg);
            end
            if (w > 0) begin
                tests++;
                if (cyc - t_prev != NB + 2) begin
                    fails++;
                    $display("FAIL rr_period%0d got %0d want %0d", w, cyc - t_prev, NB + 2);
                end
            end
            t_prev = cyc;
            n = 0;
            while (!bus.dataValid && n < 40) begin
                n++;
                tick();
            end
            ed = 8'(8'h10 + (w % 4));
            tests++;
            if (bus.dataValid !== 1'b1 || bus.parallelDataOut !== ed ||
                bus.laneId !== 2'(w % 4)) begin
                fails++;
                $display("FAIL rr_word%0d got v%b %h lane %0d want v1 %h lane %0d",
                         w, bus.dataValid, bus.parallelDataOut, bus.laneId, ed, w % 4);
            end
            if (w == 4) bus.req = 4'h0;
        end
        tick();
        tick();
        tests++;
        if (bus.grant !== 4'h0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL rr_drain got grant %b busy %b want 0000 0", bus.grant, bus.busy);
        end
        bus.dataReady = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        lane_data[2] = 8'h3C;
        lane_par[2]  = 1'b0;
        bus.dataReady = 1'b0;
        bus.req = 4'b0100;
        n = 0;
        while (bus.grant == 4'h0 && n < 40) begin
            n++;
            tick();
        end
        tests++;
        if (bus.grant !== 4'b0100) begin
            fails++; $display("FAIL bp_grant got %b want 0100", bus.grant);
        end
        n = 0;
        while (!bus.dataValid && n < 40) begin
            n++;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (bus.dataValid !== 1'b1 || bus.parallelDataOut !== 8'h3C ||
                bus.laneId !== 2'd2 || bus.grant !== 4'h0) begin
                fails++;
                $display("FAIL bp_hold%0d got v%b %h lane %0d grant %b want v1 3c lane 2 0000",
                         k, bus.dataValid, bus.parallelDataOut, bus.laneId, bus.grant);
            end
            tick();
        end
        bus.dataReady = 1'b1;
        bus.req = 4'h0;
        tick();
        tests++;
        if (bus.dataValid !== 1'b0) begin
            fails++; $display("FAIL bp_accept got v%b want 0", bus.dataValid);
        end
        bus.dataReady = 1'b0;
        tick();
        tests++;
        if (bus.dataValid !== 1'b0 || bus.grant !== 4'h0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_once got v%b grant %b busy %b want 0 0000 0",
                     bus.dataValid, bus.grant, bus.busy);
        end
    endtask

    task automatic test_abort_reset();
        int n;
        lane_data[1] = 8'hF0;
        bus.req = 4'b0110;
        n = 0;
        while (bus.grant == 4'h0 && n < 40) begin
            n++;
            tick();
        end
        tests++;
        if (bus.grant !== 4'b0010) begin
            fails++; $display("FAIL abort_grant got %b want 0010", bus.grant);
        end
        tick();
        tick();
        tick();
        bus.req = 4'b0100;
        tick();
        tests++;
        if (bus.grant !== 4'h0 || bus.dataValid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.parallelDataOut !== 8'h3C) begin
            fails++;
            $display("FAIL abort_drop got grant %b v%b busy %b %h want 0000 0 0 3c",
                     bus.grant, bus.dataValid, bus.busy, bus.parallelDataOut);
        end
        tick();
        tests++;
        if (bus.grant !== 4'b0100) begin
            fails++; $display("FAIL abort_next got %b want 0100", bus.grant);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if (bus.grant !== 4'h0 || bus.dataValid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.parallelDataOut !== 8'h00 || bus.laneId !== 2'd0) begin
            fails++;
            $display("FAIL midreset got grant %b v%b busy %b %h lane %0d want all 0",
                     bus.grant, bus.dataValid, bus.busy, bus.parallelDataOut, bus.laneId);
        end
        reset = 1'b1;
        bus.req = 4'hF;
        tick();
        tests++;
        if (bus.grant !== 4'b0001) begin
            fails++; $display("FAIL postreset_grant got %b want 0001", bus.grant);
        end
        bus.req = 4'h0;
        tick();
        tick();
    endtask

`ifdef S2P_ARB_PARITY_EN
    task automatic test_parity();
        int n;
        pulse_reset();
        for (int w = 0; w < 2; w++) begin
            lane_data[0] = 8'hA5;
            lane_par[0]  = (w == 1);
            bus.dataReady = 1'b0;
            bus.req = 4'b0001;
            n = 0;
            while (bus.grant == 4'h0 && n < 40) begin
                n++;
                tick();
            end
            n = 0;
            while (bus.grant == 4'b0001 && n < 40) begin
                n++;
                tick();
            end
            tests++;
            if (n != 9) begin
                fails++; $display("FAIL par_len%0d got %0d want 9", w, n);
            end
            tests++;
            if (bus.dataValid !== 1'b1 || bus.parallelDataOut !== 8'hA5 ||
                bus.parityErr !== (w == 1)) begin
                fails++;
                $display("FAIL par_word%0d got v%b %h perr %b want v1 a5 perr %0d",
                         w, bus.dataValid, bus.parallelDataOut, bus.parityErr, w);
            end
            bus.req = 4'h0;
            bus.dataReady = 1'b1;
            tick();
            tests++;
            if (bus.parityErr !== 1'b0 || bus.dataValid !== 1'b0) begin
                fails++;
                $display("FAIL par_clear%0d got perr %b v%b want 0 0",
                         w, bus.parityErr, bus.dataValid);
            end
        end
        bus.dataReady = 1'b0;
        tick();
    endtask
`endif

    initial begin
        bus.req = '0;
        bus.dataReady = 1'b0;
        bus.serialDataIn = '0;
        for (int i = 0; i < LANES; i++) begin
            ptr[i] = 0;
            lane_data[i] = 8'h00;
            lane_par[i] = 1'b0;
        end
        drive_serial();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_abort_reset();
`ifdef S2P_ARB_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
